// File: rtl/ber_checker_pkg.sv
// Shared constants, state encoding and LFSR step for the BER checker.
// Combinational helpers only; no storage.
// Used by the reference generator and the top-level checker.
package ber_checker_pkg;

  // PRBS9 (x^9 + x^5 + 1): sequence length and feedback taps
  localparam int PRBS_PERIOD = 511;
  localparam int PRBS_TAP_HI = 8;
  localparam int PRBS_TAP_LO = 4;

  // Largest selectable reference delay tap
  localparam int MAX_DELAY = PRBS_PERIOD - 1;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // One Fibonacci step; the output bit is the MSB before the step
  function automatic logic [8:0] prbs9_next(input logic [8:0] s);
    return {s[7:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/ber_checker_prbs9_en.sv
// Clock-enabled PRBS9 reference generator.
// o_bit is valid combinationally from state; it advances one step per i_en.
// No backpressure: i_en low simply holds the sequence position.
module prbs9_en
  import ber_checker_pkg::*;
#(
  parameter logic [8:0] SEED = 9'b010101011
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_bit
);

  logic [8:0] lfsr;

  // Advance the LFSR only on enabled cycles; reset reloads the seed
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= SEED;
    end else if (i_en) begin
      lfsr <= prbs9_next(lfsr);
    end
  end

  assign o_bit = lfsr[PRBS_TAP_HI];

endmodule

// File: rtl/ber_checker.sv
// QPSK receive BER checker: decimate, slice by sign, search PRBS9 delay, count bits/errors.
// Results are registered on the symbol edge and visible the following cycle.
// i_enable low freezes every register; there is no other flow control.
module ber_checker
  import ber_checker_pkg::*;
#(
  parameter logic [8:0] SEED     = 9'b010101011,
  parameter int         OS       = 4,
  parameter int         WIN      = 128,
  parameter int         LOSS_THR = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [1:0]  i_phase,
  input  logic [15:0] i_sample,
  output logic        o_lock,
  output logic [8:0]  o_delay,
  output logic [63:0] o_bit_cnt,
  output logic [63:0] o_err_cnt
);

  localparam int WW = $clog2(WIN);
  localparam int EW = $clog2(WIN + 1);

  state_t                 state;
  logic [1:0]             phase_cnt;
  logic [PRBS_PERIOD-1:0] line;
  logic [WW-1:0]          win_cnt;
  logic [EW-1:0]          win_err;

  logic          sym_ev;
  logic          rx_bit;
  logic          ref_bit;
  logic          cmp_err;
  logic          win_end;
  logic [EW-1:0] err_next;
  logic [8:0]    delay_inc;

  // Symbol strobe: a phase index that the counter never reaches never fires
  assign sym_ev    = i_enable & (phase_cnt == i_phase);
  assign rx_bit    = ~i_sample[15];
  assign cmp_err   = rx_bit ^ line[o_delay];
  assign win_end   = (win_cnt == WW'(WIN - 1));
  assign err_next  = win_err + {{(EW-1){1'b0}}, cmp_err};
  assign delay_inc = (o_delay == 9'(MAX_DELAY)) ? 9'd0 : o_delay + 9'd1;

  prbs9_en #(.SEED(SEED)) u_ref (
    .clk  (clk),
    .rst  (rst),
    .i_en (sym_ev),
    .o_bit(ref_bit)
  );

  // Free-running sample phase inside the symbol, frozen while disabled
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_cnt <= 2'd0;
    end else if (i_enable) begin
      phase_cnt <= (phase_cnt == 2'(OS - 1)) ? 2'd0 : phase_cnt + 2'd1;
    end
  end

  // Reference history: line[0] holds the most recent reference bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      line <= '0;
    end else if (sym_ev) begin
      line <= {line[PRBS_PERIOD-2:0], ref_bit};
    end
  end

  // Window FSM with delay search and saturating locked-mode counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_SEARCH;
      o_lock    <= 1'b0;
      o_delay   <= 9'd0;
      win_cnt   <= '0;
      win_err   <= '0;
      o_bit_cnt <= '0;
      o_err_cnt <= '0;
    end else if (sym_ev) begin
      case (state)
        ST_SEARCH: begin
          if (win_end) begin
            win_cnt <= '0;
            win_err <= '0;
            if (err_next == '0) begin
              state  <= ST_LOCKED;
              o_lock <= 1'b1;
            end else begin
              o_delay <= delay_inc;
            end
          end else begin
            win_cnt <= win_cnt + WW'(1);
            win_err <= err_next;
          end
        end
        ST_LOCKED: begin
          if (o_bit_cnt != '1) o_bit_cnt <= o_bit_cnt + 64'd1;
          if (cmp_err && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + 64'd1;
          // Only a burst of LOSS_THR errors in one window drops lock; isolated
          // errors just roll off at the window boundary with the tap kept.
          if (err_next == EW'(LOSS_THR)) begin
            state   <= ST_SEARCH;
            o_lock  <= 1'b0;
            o_delay <= delay_inc;
            win_cnt <= '0;
            win_err <= '0;
          end else if (win_end) begin
            win_cnt <= '0;
            win_err <= '0;
          end else begin
            win_cnt <= win_cnt + WW'(1);
            win_err <= err_next;
          end
        end
        default: begin
          state  <= ST_SEARCH;
          o_lock <= 1'b0;
        end
      endcase
    end
  end

endmodule
